// File: rtl/flit_queue_pkg.sv
// Shared flit types for the router/NIC flit paths.
// The queue itself only uses $bits(types::flit_t) and never looks at the fields.
package types;

    typedef struct packed {
        logic [7:0] dst_id;
        logic [7:0] src_id;
    } header_t;

    typedef struct packed {
        header_t     header;
        logic [31:0] payload;
    } flit_t;

    localparam int FLIT_W = $bits(flit_t);

endpackage

// File: rtl/flit_queue.sv
// Circular-buffer flit FIFO with valid/ready on both sides.
// The head is shown combinationally from storage; both flags come from state only.
module flit_queue
    import types::*;
#(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [$bits(types::flit_t)-1:0]  pushed_flit,
    input  logic                             pushed_flit_valid,
    output logic                             pushed_flit_ready,
    input  logic                             poped_flit_ready,
    output logic                             poped_flit_valid,
    output logic [$bits(types::flit_t)-1:0]  poped_flit
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);

    logic [FLIT_W-1:0] mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    assign pushed_flit_ready = (count != FULL_COUNT);
    assign poped_flit_valid  = (count != '0);

    assign push = pushed_flit_valid && pushed_flit_ready;
    assign pop  = poped_flit_ready && poped_flit_valid;

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pushed_flit;
        end
    end

    assign poped_flit = poped_flit_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_flit_queue.sv
// Directed bench for flit_queue (depth 4): handshakes, boundaries, wrap and reset.
module tb_flit_queue;
    import types::*;

    logic              clk;
    logic              rst_n;
    logic [FLIT_W-1:0] pushed_flit;
    logic              pushed_flit_valid;
    logic              pushed_flit_ready;
    logic              poped_flit_ready;
    logic              poped_flit_valid;
    logic [FLIT_W-1:0] poped_flit;

    int tests_run;
    int tests_failed;

    flit_queue #(.QUEUE_DEPTH(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pushed_flit       (pushed_flit),
        .pushed_flit_valid (pushed_flit_valid),
        .pushed_flit_ready (pushed_flit_ready),
        .poped_flit_ready  (poped_flit_ready),
        .poped_flit_valid  (poped_flit_valid),
        .poped_flit        (poped_flit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic flit_t mk(input logic [7:0] id);
        flit_t f;
        f.header.src_id = id;
        f.header.dst_id = ~id;
        f.payload       = {id, 8'hA5, id, 8'h3C};
        return f;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [7:0] id);
        flit_t f;
        f = flit_t'(poped_flit);
        check({tag, "_valid"}, 64'(poped_flit_valid), 64'd1);
        check({tag, "_src"}, 64'(f.header.src_id), 64'(id));
        check({tag, "_flit"}, 64'(poped_flit), 64'(mk(id)));
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"}, 64'(poped_flit_valid), 64'd0);
        check({tag, "_flit"}, 64'(poped_flit), 64'd0);
        check({tag, "_ready"}, 64'(pushed_flit_ready), 64'd1);
    endtask

    initial begin
        logic [7:0] base;
        tests_run         = 0;
        tests_failed      = 0;
        rst_n             = 1'b0;
        pushed_flit       = '0;
        pushed_flit_valid = 1'b0;
        poped_flit_ready  = 1'b0;

        #2;
        check_empty("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_empty("post_reset");

        // single push then pop
        pushed_flit = mk(8'h01); pushed_flit_valid = 1'b1;
        step();
        pushed_flit_valid = 1'b0;
        check("push1_ready", 64'(pushed_flit_ready), 64'd1);
        check_head("push1", 8'h01);
        poped_flit_ready = 1'b1;
        step();
        poped_flit_ready = 1'b0;
        check_empty("pop1");

        // three pushes, head holds
        pushed_flit = mk(8'h02); pushed_flit_valid = 1'b1;
        step();
        check_head("p02", 8'h02);
        pushed_flit = mk(8'h03);
        step();
        check_head("p03", 8'h02);
        check("p03_ready", 64'(pushed_flit_ready), 64'd1);
        pushed_flit = mk(8'h04);
        step();
        pushed_flit_valid = 1'b0;
        check_head("p04", 8'h02);
        check("p04_ready", 64'(pushed_flit_ready), 64'd1);
        poped_flit_ready = 1'b1;
        step();
        check_head("pop_to03", 8'h03);
        step();
        poped_flit_ready = 1'b0;
        check_head("pop_to04", 8'h04);

        // one entry: simultaneous push and pop
        pushed_flit = mk(8'h05); pushed_flit_valid = 1'b1; poped_flit_ready = 1'b1;
        step();
        pushed_flit_valid = 1'b0;
        check_head("swap05", 8'h05);
        check("swap05_ready", 64'(pushed_flit_ready), 64'd1);
        step();
        poped_flit_ready = 1'b0;
        check_empty("after05");

        // fill to full
        pushed_flit_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pushed_flit = mk(8'h10 + 8'(i));
            step();
        end
        check("full_ready", 64'(pushed_flit_ready), 64'd0);
        check_head("full_head", 8'h10);
        pushed_flit = mk(8'h14);
        step();
        check("full_drop_ready", 64'(pushed_flit_ready), 64'd0);
        check_head("full_drop", 8'h10);
        pushed_flit = mk(8'h15); poped_flit_ready = 1'b1;
        step();
        pushed_flit_valid = 1'b0;
        check_head("full_pushpop", 8'h11);
        check("full_pushpop_ready", 64'(pushed_flit_ready), 64'd1);
        step();
        check_head("drain12", 8'h12);
        step();
        check_head("drain13", 8'h13);
        step();
        poped_flit_ready = 1'b0;
        check_empty("drained");

        // wrap-around laps
        for (int lap = 0; lap < 3; lap++) begin
            base = 8'h20 + 8'(lap * 16);
            pushed_flit_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                pushed_flit = mk(base + 8'(i));
                step();
            end
            pushed_flit_valid = 1'b0;
            check("lap_full_ready", 64'(pushed_flit_ready), 64'd0);
            check_head("lap_fill", base);
            poped_flit_ready = 1'b1;
            step();
            check_head("lap_pop1", base + 8'd1);
            step();
            poped_flit_ready = 1'b0;
            check_head("lap_pop2", base + 8'd2);
            pushed_flit_valid = 1'b1;
            pushed_flit = mk(base + 8'd4);
            step();
            check("lap_refill1_ready", 64'(pushed_flit_ready), 64'd1);
            pushed_flit = mk(base + 8'd5);
            step();
            pushed_flit_valid = 1'b0;
            check("lap_refill2_ready", 64'(pushed_flit_ready), 64'd0);
            check_head("lap_refill", base + 8'd2);
            poped_flit_ready = 1'b1;
            for (int i = 3; i < 6; i++) begin
                step();
                check_head("lap_drain", base + 8'(i));
            end
            step();
            poped_flit_ready = 1'b0;
            check_empty("lap_empty");
        end

        // pop while empty
        poped_flit_ready = 1'b1;
        step();
        poped_flit_ready = 1'b0;
        check_empty("pop_empty");

        // reset mid-fill
        pushed_flit_valid = 1'b1;
        pushed_flit = mk(8'h40);
        step();
        pushed_flit = mk(8'h41);
        step();
        pushed_flit_valid = 1'b0;
        check_head("prereset", 8'h40);
        #2 rst_n = 1'b0;
        #1;
        check_empty("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_empty("after_reset");
        pushed_flit = mk(8'h50); pushed_flit_valid = 1'b1;
        step();
        pushed_flit_valid = 1'b0;
        check_head("post_reset_push", 8'h50);
        poped_flit_ready = 1'b1;
        step();
        poped_flit_ready = 1'b0;
        check_empty("post_reset_pop");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
